mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Arbitrates one shared single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw).
- Sequences each access through a fixed-latency memory protocol and returns data with a one-cycle `Ready` pulse.
- Drives pipeline freeze signals alongside the hazard detection unit's stalls.
- MEM has priority; a burst limiter keeps fetch from starving.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from `Mem_En` to valid `Mem_RData` (legal range 1–7).
- `MAX_MEM_BURST`, 4: consecutive MEM grants allowed while IF waits (legal range 1–15).
- `Clock`  in  1  single clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `IF_Req`  in  1  fetch request; held until `IF_Ready`.
- `IF_Addr`  in  ADDR_W  fetch address.
- `IF_Ready`  out  1  one-cycle completion pulse for fetch.
- `IF_Data`  out  DATA_W  instruction word; valid while `IF_Ready`=1.
- `MEM_Req`  in  1  data request; held until `MEM_Ready`.
- `MEM_Write`  in  1  1=sw, 0=lw.
- `MEM_Addr`  in  ADDR_W  data address.
- `MEM_WData`  in  DATA_W  store data.
- `MEM_Ready`  out  1  one-cycle completion pulse for data access.
- `MEM_RData`  out  DATA_W  load data; valid while `MEM_Ready`=1.
- `Mem_En`  out  1  memory access strobe, one cycle per access.
- `Mem_We`  out  1  write enable, qualified by `Mem_En`.
- `Mem_Addr`  out  ADDR_W  memory address.
- `Mem_WData`  out  DATA_W  memory write data.
- `Mem_RData`  in  DATA_W  memory read data.
- `Stall_Fetch`  out  1  `IF_Req & ~IF_Ready`; freezes PC and IF/ID.
- `Stall_Mem`  out  1  `MEM_Req & ~MEM_Ready`; freezes PC through EX/MEM.

## Operation
**States:**
- IDLE: no access in flight.
- ACCESS: counter counts down.
- RESP: `Ready` pulse.

**IDLE grant rule:**
- Grant goes to MEM if `MEM_Req` and not (`IF_Req` and `burst_cnt`==`MAX_MEM_BURST`).
- Otherwise grant goes to IF if `IF_Req`.
- Otherwise stay in IDLE.

**On grant:**
- Latch owner, address, write flag and write data.
- Load `lat_cnt` = `MEM_LAT` for reads, 0 for writes.
- Go to ACCESS.

**ACCESS:**
- First cycle only: `Mem_En`=1, `Mem_We`=latched write flag, `Mem_Addr`/`Mem_WData` = latched values.
- Decrement `lat_cnt` each cycle.
- When `lat_cnt`==0:
  - for reads, register `Mem_RData` into the owner's data register;
  - go to RESP.

**RESP:**
- Assert the owner's `Ready` for exactly one cycle.
- Go to IDLE.
- Writes never assert `IF_Ready`; IF is read-only.

**burst_cnt:**
- Increments on each MEM grant while `IF_Req`=1.
- Clears on any IF grant, and when `IF_Req`=0 at a MEM grant.
- Saturates at `MAX_MEM_BURST`.

**Boundary rules:**
- Request dropped mid-access: the access completes and `Ready` still pulses; the requester ignores it.
- `IF_Req` rising while MEM is in flight: queued, evaluated at the next IDLE.
- Both requests in the same IDLE cycle: MEM wins unless burst-limited.
- `MEM_Write` with `MEM_Addr` equal to a fetch address: no coherence action; accesses are serialized.
- Reset mid-access: in-flight access abandoned, no `Ready` pulse, `Mem_En` deasserts immediately.

## Timing
**Reset values (all outputs 0):**
- `IF_Ready`, `MEM_Ready`, `Mem_En`, `Mem_We` = 0.
- `IF_Data`, `MEM_RData`, `Mem_Addr`, `Mem_WData` = 0.
- State = IDLE, `burst_cnt` = 0.

**Cycle-level timeline (request seen in IDLE at cycle t):**
- `Mem_En` at t+1.
- Read data sampled at t+1+`MEM_LAT`.
- Read `Ready` at t+2+`MEM_LAT`.
- Write `Ready` at t+2.
- Next grant is evaluated the cycle after RESP. Back-to-back issue spacing is therefore `MEM_LAT`+3 cycles for reads and 3 for writes.

**Output timing:**
- `Stall_Fetch`/`Stall_Mem` are combinational from the request inputs and registered `Ready`.
- `Mem_*` outputs are registered.

## Structure
- Shared definitions file `mem_arb_defs`:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - owner encoding (OWN_IF=1'b0, OWN_MEM=1'b1).
- One natural sub-module, `mem_arb_burst_counter`: saturating `burst_cnt` with clear/increment inputs and a `limit_hit` output.
- FSM, latches and data registers stay in the top module.

## Test plan
- **Reset:** assert `Reset`=0 mid-ACCESS (MEM read, `lat_cnt`=1) → all outputs 0 the same cycle; no `MEM_Ready` after release; IDLE.
- **Single fetch:** `IF_Req`=1, `IF_Addr`=0x40, memory returns 0x8C080004 → `Mem_En` one cycle at t+1 with `Mem_Addr`=0x40; `IF_Ready`=1 at t+4 with `IF_Data`=0x8C080004; `Stall_Fetch`=1 during t..t+3.
- **Store:** `MEM_Req`=1, `MEM_Write`=1, `MEM_Addr`=0x100, `MEM_WData`=0xDEADBEEF → `Mem_En`=`Mem_We`=1 at t+1 with those values; `MEM_Ready` at t+2; `IF_Ready` never asserted.
- **Simultaneous requests:** `IF_Req`=`MEM_Req`=1 in IDLE, MEM read 0x200 → MEM served first; IF `Mem_En` occurs at `MEM_Ready`+2.
- **Starvation guard:** `IF_Req` held, 6 consecutive MEM loads, `MAX_MEM_BURST`=4 → grant order MEM,MEM,MEM,MEM,IF,MEM,MEM; `burst_cnt` clears at the IF grant.
- **Dropped request:** `MEM_Req` deasserted at t+2 of a read → `Mem_En` issued once; `MEM_Ready` still pulses at t+4; next grant evaluated at t+5.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the unified memory port arbiter.
// Imported by the arbiter top and its burst counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    // Wide enough for MEM_LAT up to 7 and MAX_MEM_BURST up to 15.
    localparam int LAT_W   = 3;
    localparam int BURST_W = 4;

    // Writes complete without waiting for read data to come back.
    function automatic logic [LAT_W-1:0] access_latency(input logic is_write, input int mem_lat);
        return is_write ? '0 : LAT_W'(mem_lat);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-access, memory and freeze signals around the arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_Req;
    logic [ADDR_W-1:0] IF_Addr;
    logic              IF_Ready;
    logic [DATA_W-1:0] IF_Data;

    logic              MEM_Req;
    logic              MEM_Write;
    logic [ADDR_W-1:0] MEM_Addr;
    logic [DATA_W-1:0] MEM_WData;
    logic              MEM_Ready;
    logic [DATA_W-1:0] MEM_RData;

    logic              Mem_En;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_WData;
    logic [DATA_W-1:0] Mem_RData;

    logic              Stall_Fetch;
    logic              Stall_Mem;

    modport slave (
        input  IF_Req, IF_Addr, MEM_Req, MEM_Write, MEM_Addr, MEM_WData, Mem_RData,
        output IF_Ready, IF_Data, MEM_Ready, MEM_RData,
        output Mem_En, Mem_We, Mem_Addr, Mem_WData, Stall_Fetch, Stall_Mem
    );

    modport master (
        output IF_Req, IF_Addr, MEM_Req, MEM_Write, MEM_Addr, MEM_WData, Mem_RData,
        input  IF_Ready, IF_Data, MEM_Ready, MEM_RData,
        input  Mem_En, Mem_We, Mem_Addr, Mem_WData, Stall_Fetch, Stall_Mem
    );

endinterface

// File: rtl/mem_port_arbiter_burst_counter.sv
// Saturating count of consecutive MEM grants taken while a fetch was waiting.
// limit_hit tells the arbiter to hand the next grant to fetch.
module mem_arb_burst_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_MEM_BURST = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic inc,
    output logic limit_hit
);

    localparam logic [BURST_W-1:0] LIMIT = BURST_W'(MAX_MEM_BURST);

    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (clr) begin
            burst_cnt_d = '0;
        end else if (inc && (burst_cnt_q != LIMIT)) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign limit_hit = (burst_cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the MEM stage; MEM has priority, bounded by a burst limiter.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e        state_q,     state_d;
    arb_owner_e        owner_q,     owner_d;
    logic              wr_q,        wr_d;
    logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] if_data_q,   if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic burst_clr;
    logic burst_inc;
    logic limit_hit;

    mem_arb_burst_counter #(
        .MAX_MEM_BURST (MAX_MEM_BURST)
    ) u_burst (
        .Clock     (Clock),
        .Reset     (Reset),
        .clr       (burst_clr),
        .inc       (burst_inc),
        .limit_hit (limit_hit)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        lat_cnt_d   = lat_cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        burst_clr   = 1'b0;
        burst_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                // A waiting fetch only overrides MEM once the burst limit is reached.
                if (bus.MEM_Req && !(bus.IF_Req && limit_hit)) begin
                    owner_d     = OWN_MEM;
                    wr_d        = bus.MEM_Write;
                    lat_cnt_d   = access_latency(bus.MEM_Write, MEM_LAT);
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.MEM_Write;
                    mem_addr_d  = bus.MEM_Addr;
                    mem_wdata_d = bus.MEM_WData;
                    burst_inc   = bus.IF_Req;
                    burst_clr   = !bus.IF_Req;
                    state_d     = ACCESS;
                end else if (bus.IF_Req) begin
                    owner_d    = OWN_IF;
                    wr_d       = 1'b0;
                    lat_cnt_d  = access_latency(1'b0, MEM_LAT);
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.IF_Addr;
                    burst_clr  = 1'b1;
                    state_d    = ACCESS;
                end
            end

            ACCESS: begin
                if (lat_cnt_q == '0) begin
                    if (!wr_q) begin
                        if (owner_q == OWN_IF) begin
                            if_data_d = bus.Mem_RData;
                        end else begin
                            mem_rdata_d = bus.Mem_RData;
                        end
                    end
                    if_ready_d  = (owner_q == OWN_IF) && !wr_q;
                    mem_ready_d = (owner_q == OWN_MEM);
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset abandons any access in flight and clears every registered output.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            wr_q        <= 1'b0;
            lat_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.Mem_En      = mem_en_q;
    assign bus.Mem_We      = mem_we_q;
    assign bus.Mem_Addr    = mem_addr_q;
    assign bus.Mem_WData   = mem_wdata_q;
    assign bus.IF_Ready    = if_ready_q;
    assign bus.IF_Data     = if_data_q;
    assign bus.MEM_Ready   = mem_ready_q;
    assign bus.MEM_RData   = mem_rdata_q;
    assign bus.Stall_Fetch = bus.IF_Req & ~if_ready_q;
    assign bus.Stall_Mem   = bus.MEM_Req & ~mem_ready_q;

endmodule
